// File: rtl/systolic_skew_feeder_if.sv
// Input stream bundle for the systolic skew feeder.
// One beat carries a full K-slice: N activations and N weights.
//   s_valid  source -> feeder   beat valid
//   s_ready  feeder -> source   feeder accepts the beat this cycle
//   s_a      source -> feeder   activations, lane i = bits [i*DATA_W +: DATA_W]
//   s_w      source -> feeder   weights,     lane j = bits [j*DATA_W +: DATA_W]
interface systolic_skew_feeder_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [N*DATA_W-1:0]   s_a;
  logic [N*DATA_W-1:0]   s_w;

  modport master (output s_valid, output s_a, output s_w, input s_ready);
  modport slave  (input s_valid, input s_a, input s_w, output s_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for an NxN systolic array. Accepts one K-slice per beat,
// skews lane i by i cycles to form the diagonal wavefront, frames a tile of
// k_len beats, drains zeros through the array and pulses tile_done.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   start      begin a tile (only honoured in IDLE)
//   k_len      beats in the tile, captured with start
//   s          input stream (valid/ready, activations, weights)
//   a_out      skewed activations to array rows
//   w_out      skewed weights to array columns
//   busy       high while a tile is in progress (FEED, DRAIN, DONE)
//   tile_done  one-cycle pulse at the end of a tile
module systolic_skew_feeder #(
  parameter int DATA_W    = 8,
  parameter int N         = 4,
  parameter int KLEN_W    = 8,
  parameter int DRAIN_CYC = 3*N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KLEN_W-1:0]      k_len,
  systolic_skew_feeder_if.slave  s,
  output logic [N*DATA_W-1:0]    a_out,
  output logic [N*DATA_W-1:0]    w_out,
  output logic                   busy,
  output logic                   tile_done
);

  localparam int DCNT_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [KLEN_W-1:0]   klen_reg;
  logic [KLEN_W-1:0]   beat_cnt_reg;
  logic [DCNT_W-1:0]   drain_cnt_reg;

  logic                accept;
  logic                last_beat;
  logic                drain_end;
  logic [N*DATA_W-1:0] a_slice;
  logic [N*DATA_W-1:0] w_slice;

  assign accept    = s.s_valid && s.s_ready;
  assign last_beat = accept && (beat_cnt_reg == klen_reg - KLEN_W'(1));
  assign drain_end = (drain_cnt_reg == DCNT_W'(DRAIN_CYC - 1));

  // Anything other than an accepted beat enters the lanes as a zero slice,
  // so bubbles behave as a zero K-slice and alignment is never broken.
  assign a_slice = accept ? s.s_a : '0;
  assign w_slice = accept ? s.s_w : '0;

  always_comb begin
    state_next = state_reg;
    s.s_ready  = 1'b0;
    busy       = 1'b1;
    tile_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start && (k_len != '0)) state_next = FEED;
      end
      FEED: begin
        s.s_ready = 1'b1;
        if (last_beat) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_end) state_next = DONE;
      end
      DONE: begin
        tile_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      klen_reg      <= '0;
      beat_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start && (k_len != '0)) begin
            klen_reg     <= k_len;
            beat_cnt_reg <= '0;
          end
        end
        FEED: begin
          if (accept) beat_cnt_reg <= beat_cnt_reg + KLEN_W'(1);
          if (last_beat) drain_cnt_reg <= '0;
        end
        DRAIN: drain_cnt_reg <= drain_cnt_reg + DCNT_W'(1);
        default: ;
      endcase
    end
  end

  // Lane gi: gi shift stages plus one output register, so a slice entering
  // at cycle t shows up on lane gi at cycle t+1+gi.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [DATA_W-1:0] a_pipe_reg [0:gi];
    logic [DATA_W-1:0] w_pipe_reg [0:gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= gi; k++) begin
          a_pipe_reg[k] <= '0;
          w_pipe_reg[k] <= '0;
        end
      end else begin
        a_pipe_reg[0] <= a_slice[gi*DATA_W +: DATA_W];
        w_pipe_reg[0] <= w_slice[gi*DATA_W +: DATA_W];
        for (int k = 1; k <= gi; k++) begin
          a_pipe_reg[k] <= a_pipe_reg[k-1];
          w_pipe_reg[k] <= w_pipe_reg[k-1];
        end
      end
    end

    assign a_out[gi*DATA_W +: DATA_W] = a_pipe_reg[gi];
    assign w_out[gi*DATA_W +: DATA_W] = w_pipe_reg[gi];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (N=4, DATA_W=8).
// The stimulus process records, per future cycle, the lane bytes each
// accepted beat must produce and the cycle tile_done must fire; a monitor
// compares outputs against that record on every falling edge.
module tb_systolic_skew_feeder;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int KLEN_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [KLEN_W-1:0] k_len = '0;
  logic [31:0]       a_out, w_out;
  logic              busy, tile_done;

  systolic_skew_feeder_if #(.N(N), .DATA_W(DATA_W)) sif ();

  systolic_skew_feeder #(.DATA_W(DATA_W), .N(N), .KLEN_W(KLEN_W), .DRAIN_CYC(3*N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .s         (sif.slave),
    .a_out     (a_out),
    .w_out     (w_out),
    .busy      (busy),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  logic [31:0] exp_a [int];
  logic [31:0] exp_w [int];
  int          done_q [$];

  // Directed tile data
  logic [31:0] a_vec [$];
  logic [31:0] w_vec [$];
  bit          val_pat [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat accepted in cycle t: lane i byte appears at cycle t+1+i.
  task automatic push_beat(input int t, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] ta, tw;
    int k;
    for (int i = 0; i < N; i++) begin
      k = t + 1 + i;
      ta = exp_a.exists(k) ? exp_a[k] : 32'h0;
      tw = exp_w.exists(k) ? exp_w[k] : 32'h0;
      ta[i*8 +: 8] = a[i*8 +: 8];
      tw[i*8 +: 8] = w[i*8 +: 8];
      exp_a[k] = ta;
      exp_w[k] = tw;
    end
  endtask

  task automatic drop_after(input int r);
    int keys [$];
    foreach (exp_a[k]) if (k > r) keys.push_back(k);
    foreach (keys[j]) begin
      exp_a.delete(keys[j]);
      exp_w.delete(keys[j]);
    end
  endtask

  // Runs one tile using a_vec/w_vec/val_pat. Entered and left mid-cycle
  // (just after a rising edge); leaves in the cycle after tile_done.
  task automatic run_tile(input int klen, input bit poke_start);
    int acc = 0;
    int idx = 0;
    int f = 0;
    bit v;
    start = 1'b1;
    k_len = KLEN_W'(klen);
    step();
    start = 1'b0;
    while (acc < klen && idx < 64) begin
      v = (idx < val_pat.size()) ? val_pat[idx] : 1'b1;
      sif.s_valid = v;
      sif.s_a = v ? a_vec[acc] : 32'hFFFF_FFFF;
      sif.s_w = v ? w_vec[acc] : 32'hEEEE_EEEE;
      if (poke_start && idx == 1) begin
        start = 1'b1;
        k_len = KLEN_W'(1);
      end
      @(negedge clk);
      chk("s_ready_feed", 64'(sif.s_ready), 64'(1));
      if (v) begin
        push_beat(cyc, a_vec[acc], w_vec[acc]);
        f = cyc;
        acc++;
      end
      step();
      start = 1'b0;
      idx++;
    end
    sif.s_valid = 1'b0;
    sif.s_a = 32'hFFFF_FFFF;
    sif.s_w = 32'hEEEE_EEEE;
    @(negedge clk);
    chk("s_ready_drain", 64'(sif.s_ready), 64'(0));
    chk("busy_drain", 64'(busy), 64'(1));
    done_q.push_back(f + 13);
    while (cyc < f + 14) step();
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'(0));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] ea, ew;
      bit ed;
      ea = exp_a.exists(cyc) ? exp_a[cyc] : 32'h0;
      ew = exp_w.exists(cyc) ? exp_w[cyc] : 32'h0;
      if (exp_a.exists(cyc)) begin
        exp_a.delete(cyc);
        exp_w.delete(cyc);
      end
      chk("a_out", 64'(a_out), 64'(ea));
      chk("w_out", 64'(w_out), 64'(ew));
      ed = (done_q.size() > 0 && done_q[0] == cyc);
      if (ed) void'(done_q.pop_front());
      chk("tile_done", 64'(tile_done), 64'(ed));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    // 1: reset held 3 cycles with start and s_valid asserted
    sif.s_valid = 1'b1;
    sif.s_a = 32'h5555_5555;
    sif.s_w = 32'hAAAA_AAAA;
    start = 1'b1;
    k_len = 8'd4;
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_s_ready", 64'(sif.s_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    sif.s_valid = 1'b0;
    step();
    step();

    // 2: single-beat skew
    a_vec = '{32'h0403_0201};
    w_vec = '{32'h4030_2010};
    val_pat = '{1'b1};
    run_tile(1, 1'b0);
    step();

    // 3: full tile, continuous valid
    a_vec = '{32'h1413_1211, 32'h2423_2221, 32'h3433_3231, 32'h4443_4241};
    w_vec = '{32'h9493_9291, 32'hA4A3_A2A1, 32'hB4B3_B2B1, 32'hC4C3_C2C1};
    val_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_tile(4, 1'b0);
    step();

    // 4: bubble in the middle of a tile
    a_vec = '{32'h0D0C_0B0A, 32'h1D1C_1B1A, 32'h2D2C_2B2A};
    w_vec = '{32'h7D7C_7B7A, 32'h8D8C_8B8A, 32'h9D9C_9B9A};
    val_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_tile(3, 1'b0);
    step();

    // 5a: start with k_len=0 is ignored
    start = 1'b1;
    k_len = 8'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("klen0_busy", 64'(busy), 64'(0));
    chk("klen0_s_ready", 64'(sif.s_ready), 64'(0));
    step();
    step();

    // 5b: start pulsed during FEED must not re-latch k_len
    a_vec = '{32'h6655_4433, 32'h7766_5544};
    w_vec = '{32'h0102_0304, 32'h0506_0708};
    val_pat = '{1'b1, 1'b1};
    run_tile(2, 1'b1);

    // 5c: start in the cycle after tile_done
    a_vec = '{32'hF1F2_F3F4};
    w_vec = '{32'h1F2F_3F4F};
    val_pat = '{1'b1};
    run_tile(1, 1'b0);
    step();

    // 6: reset after beat 2 of a 4-beat tile
    start = 1'b1;
    k_len = 8'd4;
    step();
    start = 1'b0;
    a_vec = '{32'hC3C2_C1C0, 32'hD3D2_D1D0};
    w_vec = '{32'h3C2C_1C0C, 32'h3D2D_1D0D};
    for (int b = 0; b < 2; b++) begin
      sif.s_valid = 1'b1;
      sif.s_a = a_vec[b];
      sif.s_w = w_vec[b];
      @(negedge clk);
      chk("s_ready_pre_rst", 64'(sif.s_ready), 64'(1));
      push_beat(cyc, a_vec[b], w_vec[b]);
      step();
    end
    sif.s_a = 32'h1234_5678;
    rst = 1'b1;
    r = cyc;
    drop_after(r);
    step();
    rst = 1'b0;
    sif.s_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_s_ready", 64'(sif.s_ready), 64'(0));
    for (int i = 0; i < 20; i++) step();

    chk("done_queue_empty", 64'(done_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
